// File: rtl/gust_pkg.sv
// rtl/gust_pkg.sv - shared types and default constants for the GUST SpMV tile sequencer
package gust_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_DRAIN  = 2'd2,
      S_RESULT = 2'd3
   } gust_state_t;

   localparam int GUST_N          = 256;
   localparam int GUST_VALUE_SIZE = 32;
   localparam int GUST_INDEX_SIZE = 8;
   localparam int GUST_ADD_LAT    = 2;

endpackage

// File: rtl/gust_lat_timer.sv
// rtl/gust_lat_timer.sv - loadable down-counter with zero flag for adder-latency wait
module gust_lat_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/gust_color_sequencer.sv
// rtl/gust_color_sequencer.sv - sequences one SpMV tile through the GUST array, one color per beat
// Optional stall counter output enabled by GUST_SEQ_PERF_EN.
module gust_color_sequencer
   import gust_pkg::*;
#(
   parameter int N            = GUST_N,
   parameter int NUM_COLORS_W = 8,
   parameter int ADD_LAT      = GUST_ADD_LAT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [NUM_COLORS_W-1:0] cfg_num_colors,
   input  logic                    sched_valid,
   output logic                    sched_ready,
   output logic                    dp_start,
   output logic                    dp_clear,
   output logic [NUM_COLORS_W-1:0] color_idx,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic                    busy,
   output logic                    done
`ifdef GUST_SEQ_PERF_EN
   ,
   output logic [31:0]             stall_cnt
`endif
);

   if (ADD_LAT < 1 || N < 1) begin : g_param_check
      $error("gust_color_sequencer: ADD_LAT and N must be at least 1");
   end

   localparam int LAT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ADD_LAT - 1);

   gust_state_t             state_q;
   logic [NUM_COLORS_W-1:0] remaining_q;
   logic [NUM_COLORS_W-1:0] color_cnt_q;
   logic                    sched_hs;
   logic                    last_beat;
   logic                    lat_zero;
   logic                    cfg_accept;

   // Gated by rst_n so no beat or result is consumed in a reset cycle.
   assign sched_ready = (state_q == S_ISSUE) && rst_n;
   assign sched_hs    = sched_ready && sched_valid;
   assign last_beat   = sched_hs && (remaining_q == NUM_COLORS_W'(1));
   assign cfg_ready   = (state_q == S_IDLE);
   assign cfg_accept  = cfg_ready && cfg_valid && rst_n;
   assign busy        = (state_q != S_IDLE);
   assign done        = res_valid && res_ready && rst_n;

   // Loaded on the final beat so res_valid rises ADD_LAT cycles after the last dp_start.
   gust_lat_timer #(
      .W (LAT_W)
   ) u_lat_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (last_beat),
      .load_val (LAT_LOAD),
      .dec      (state_q == S_DRAIN),
      .zero     (lat_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         color_cnt_q <= '0;
         dp_start    <= 1'b0;
         dp_clear    <= 1'b0;
         color_idx   <= '0;
         res_valid   <= 1'b0;
      end else begin
         dp_start <= 1'b0;
         dp_clear <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cfg_valid) begin
                  remaining_q <= cfg_num_colors;
                  color_cnt_q <= '0;
                  if (cfg_num_colors == '0) begin
                     state_q   <= S_RESULT;
                     res_valid <= 1'b1;
                  end else begin
                     state_q <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (sched_hs) begin
                  dp_start    <= 1'b1;
                  dp_clear    <= (color_cnt_q == '0);
                  color_idx   <= color_cnt_q;
                  color_cnt_q <= color_cnt_q + 1'b1;
                  remaining_q <= remaining_q - 1'b1;
                  if (last_beat) begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (lat_zero) begin
                  state_q   <= S_RESULT;
                  res_valid <= 1'b1;
               end
            end
            S_RESULT: begin
               if (res_ready) begin
                  state_q   <= S_IDLE;
                  res_valid <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef GUST_SEQ_PERF_EN
   logic stall_now;

   assign stall_now = ((state_q == S_ISSUE) && !sched_valid) ||
                      ((state_q == S_RESULT) && !res_ready);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (cfg_accept) begin
         stall_cnt <= '0;
      end else if (stall_now && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule
